vga_bus_pixel_ctrl: RTL and testbench
=====================================

Name: vga_bus_pixel_ctrl

Overview:
- Parametrised successor to the bus-mapped VGA frame-buffer writer. It decodes an 8-bit memory-mapped write bus into pixel writes on the frame buffer's A port, plus colour configuration for the VGA signal generator.
- Adds configurable geometry and pixel depth, cursor auto-increment, an optional erase-previous (moving-dot) mode, a full-screen fill engine, and busy/drop status.
- Sits between the processor bus and Frame_Buffer/VGA_Sig_Gen.

Parameters:
- BASE_ADDR, 8'hB0: first of 8 consecutive register addresses.
- X_W, 8: X coordinate width.
- Y_W, 7: Y coordinate width.
- PIX_W, 1: bits per pixel, 1..8.
- X_MAX, 159: last valid column.
- Y_MAX, 119: last valid row.
- COLOUR_W, 8: width of each colour field.
- BG_INIT, 8'h33: background reset value.
- FG_INIT, 8'hCC: foreground reset value.
- CTRL_INIT, 2'b10: control reset value. Bit0 = auto-increment, bit1 = erase-previous.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- BUS_ADDR  in  8  bus address.
- BUS_DATA  in  8  bus write data.
- BUS_WE  in  1  bus write strobe, one cycle per write.
- FB_ADDR  out  X_W+Y_W  frame-buffer address {Y,X}.
- FB_DATA  out  PIX_W  frame-buffer write data.
- FB_WE  out  1  frame-buffer write enable.
- CONFIG_COLOURS  out  2*COLOUR_W  {BG,FG} to the signal generator.
- BUSY  out  1  erase or fill in progress.
- DROP  out  1  sticky flag: a write was rejected.

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0 = X
  - 1 = Y
  - 2 = PIXEL
  - 3 = BG
  - 4 = FG
  - 5 = CTRL: bit0 auto-inc, bit1 erase, bit7 = write-1-to-clear DROP
  - 6 = FILL
  - 7 = reserved: writes ignored
- Writes to addresses outside the window: no effect.
- Reset (RESET low, asynchronous):
  - FB_WE=0, FB_ADDR=0, FB_DATA=0.
  - X=Y=0; CTRL=CTRL_INIT; CONFIG_COLOURS={BG_INIT,FG_INIT}.
  - BUSY=0, DROP=0, last-pixel-valid=0, FSM=IDLE.
  - Reset mid-fill or mid-erase aborts immediately; no further FB writes.
- X/Y writes: value truncated to X_W/Y_W bits, then clamped to X_MAX/Y_MAX. Accepted in any state.
- BG/FG/CTRL writes: take effect the next cycle, accepted in any state.
- FSM states: IDLE, WRITE, ERASE, FILL.
- IDLE, PIXEL write at cycle n:
  - Cycle n+1: FB_WE=1, FB_ADDR={Y,X}, FB_DATA=BUS_DATA[PIX_W-1:0]. State WRITE.
  - LAST <= {Y,X}; last-valid <= 1.
  - If auto-inc: X <= X+1. At X_MAX, X wraps to 0 and Y increments; at Y_MAX, Y wraps to 0.
- WRITE, next cycle:
  - If erase=1, previous LAST was valid, and previous LAST != the address just written: go to ERASE. Cycle n+2: FB_WE=1, FB_ADDR=previous LAST, FB_DATA=0. BUSY=1 during n+1 and n+2.
  - Otherwise: IDLE, FB_WE=0.
- ERASE: after one cycle, go to IDLE.
- FILL write in IDLE:
  - State FILL, BUSY=1.
  - Raster counter starts at (0,0). One FB write per cycle with FB_DATA=BUS_DATA[PIX_W-1:0].
  - Only in-range addresses are emitted: exactly (X_MAX+1)*(Y_MAX+1) writes, the first at n+1.
  - After writing (X_MAX,Y_MAX): IDLE next cycle, BUSY=0, last-valid=0.
  - Cursor X/Y are unchanged.
- PIXEL or FILL write while state != IDLE: ignored, DROP <= 1.
  - Exception: a PIXEL write in the same cycle that the FSM returns to IDLE is accepted.
- Simultaneous DROP set and CTRL bit7 clear in the same cycle: set wins.
- FB_WE is deasserted in every cycle with no write.

Optional Feature:
- Macro VGA_BUS_PIXEL_READBACK_EN.
- When defined: adds output BUS_RDATA[7:0], registered with 1-cycle latency, addressed by BUS_ADDR (reads are combinational decode, not strobed):
  - offset 0 = X
  - offset 1 = Y
  - offset 3 = BG
  - offset 4 = FG
  - offset 5 = {DROP, BUSY, 4'b0, CTRL}
  - all others, and out-of-window addresses = 8'h00
- Reset value of BUS_RDATA: 0.
- When undefined: port absent, no read logic.

Decomposition:
- Package vga_bus_pkg:
  - Register offset constants: OFF_X, OFF_Y, OFF_PIXEL, OFF_BG, OFF_FG, OFF_CTRL, OFF_FILL.
  - CTRL bit indices.
  - FSM state encoding.
- One sub-module, vga_raster_counter: X/Y counter with enable, load, X_MAX/Y_MAX wrap, and last-pixel flag. It is shared by auto-increment and fill, as two instances.

Test Plan:
- Reset, then write B0=5, B1=3, B2=1 with erase off → one cycle later FB_WE=1, FB_ADDR={7'd3,8'd5}, FB_DATA=1; next cycle FB_WE=0.
- Erase on: pixels at (5,3), then (6,3) → writes at (5,3)=1, (6,3)=1, (5,3)=0 in consecutive cycles. Second PIXEL write issued while BUSY → DROP=1 and no FB write.
- Auto-inc on, X=159, Y=119, two PIXEL writes → addresses (159,119) then (0,0).
- FILL with data 0 → exactly 19200 FB_WE cycles, first (0,0), last (159,119); BUSY deasserts the next cycle. PIXEL write mid-fill → DROP=1. CTRL write 0x80 → DROP=0.
- B0=200 → X clamps to 159; B3=0xF0 → CONFIG_COLOURS[15:8]=0xF0 one cycle later.
- RESET low for one cycle at fill word 100 → FB_WE=0 immediately, BUSY=0, colours restored to 0x33/0xCC.

Source files
------------

// File: rtl/vga_bus_pkg.sv
// Shared constants for the bus-mapped VGA pixel controller:
// register offsets, CTRL bit positions and FSM encoding.
package vga_bus_pkg;

  localparam logic [2:0] OFF_X     = 3'd0;
  localparam logic [2:0] OFF_Y     = 3'd1;
  localparam logic [2:0] OFF_PIXEL = 3'd2;
  localparam logic [2:0] OFF_BG    = 3'd3;
  localparam logic [2:0] OFF_FG    = 3'd4;
  localparam logic [2:0] OFF_CTRL  = 3'd5;
  localparam logic [2:0] OFF_FILL  = 3'd6;

  localparam int CTRL_AINC  = 0;
  localparam int CTRL_ERASE = 1;
  localparam int CTRL_DCLR  = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_ERASE,
    ST_FILL
  } state_e;

endpackage

// File: rtl/vga_raster_counter.sv
// Raster X/Y counter: clear, per-axis load, step with X_MAX/Y_MAX wrap,
// and a flag marking the last on-screen pixel.
module vga_raster_counter #(
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           clr_i,
  input  logic           en_i,
  input  logic           ld_x_i,
  input  logic           ld_y_i,
  input  logic [X_W-1:0] x_i,
  input  logic [Y_W-1:0] y_i,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic           last_o
);

  localparam logic [X_W-1:0] XM = X_W'(X_MAX);
  localparam logic [Y_W-1:0] YM = Y_W'(Y_MAX);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (en_i) begin
      if (x_q == XM) begin
        x_d = '0;
        y_d = (y_q == YM) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
    if (ld_x_i) x_d = x_i;
    if (ld_y_i) y_d = y_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (x_q == XM) && (y_q == YM);

endmodule

// File: rtl/vga_bus_pixel_ctrl.sv
// Bus-mapped frame-buffer writer with cursor, erase-previous and fill.
// Define VGA_BUS_PIXEL_READBACK_EN to add the registered BUS_RDATA port.
module vga_bus_pixel_ctrl
  import vga_bus_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hB0,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int PIX_W    = 1,
  parameter int X_MAX    = 159,
  parameter int Y_MAX    = 119,
  parameter int COLOUR_W = 8,
  parameter logic [COLOUR_W-1:0] BG_INIT = 8'h33,
  parameter logic [COLOUR_W-1:0] FG_INIT = 8'hCC,
  parameter logic [1:0] CTRL_INIT = 2'b10
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [7:0]            BUS_ADDR,
  input  logic [7:0]            BUS_DATA,
  input  logic                  BUS_WE,
  output logic [X_W+Y_W-1:0]    FB_ADDR,
  output logic [PIX_W-1:0]      FB_DATA,
  output logic                  FB_WE,
  output logic [2*COLOUR_W-1:0] CONFIG_COLOURS,
  output logic                  BUSY,
  output logic                  DROP
`ifdef VGA_BUS_PIXEL_READBACK_EN
  ,
  output logic [7:0]            BUS_RDATA
`endif
);

  localparam int AW = X_W + Y_W;
  localparam logic [X_W-1:0] XM = X_W'(X_MAX);
  localparam logic [Y_W-1:0] YM = Y_W'(Y_MAX);

  state_e state_q, state_d;
  logic [AW-1:0] fb_addr_q, fb_addr_d, last_q, prev_q;
  logic [PIX_W-1:0] fb_data_q, fb_data_d;
  logic fb_we_q, fb_we_d;
  logic last_v_q, prev_v_q, drop_q;
  logic [1:0] ctrl_q;
  logic [COLOUR_W-1:0] bg_q, fg_q;

  logic [7:0] off;
  logic in_win, wr, wr_x, wr_y, wr_pix;
  logic wr_bg, wr_fg, wr_ctrl, wr_fill;
  logic [X_W-1:0] xt, xc, cx, fx;
  logic [Y_W-1:0] yt, yc, cy, fy;
  logic cur_en, f_clr, f_en, f_last, unused_cur_last;
  logic go_erase, ret_idle, pix_ok, fill_ok, drop_set;

  assign off     = BUS_ADDR - BASE_ADDR;
  assign in_win  = (off[7:3] == 5'd0);
  assign wr      = BUS_WE && in_win;
  assign wr_x    = wr && (off[2:0] == OFF_X);
  assign wr_y    = wr && (off[2:0] == OFF_Y);
  assign wr_pix  = wr && (off[2:0] == OFF_PIXEL);
  assign wr_bg   = wr && (off[2:0] == OFF_BG);
  assign wr_fg   = wr && (off[2:0] == OFF_FG);
  assign wr_ctrl = wr && (off[2:0] == OFF_CTRL);
  assign wr_fill = wr && (off[2:0] == OFF_FILL);

  // Truncate to coordinate width first, then clamp to the visible area.
  assign xt = X_W'(BUS_DATA);
  assign yt = Y_W'(BUS_DATA);
  assign xc = (xt > XM) ? XM : xt;
  assign yc = (yt > YM) ? YM : yt;

  vga_raster_counter #(
    .X_W(X_W), .Y_W(Y_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX)
  ) u_cursor (
    .clk_i(CLK), .rst_ni(RESET),
    .clr_i(1'b0), .en_i(cur_en),
    .ld_x_i(wr_x), .ld_y_i(wr_y),
    .x_i(xc), .y_i(yc),
    .x_o(cx), .y_o(cy), .last_o(unused_cur_last)
  );

  vga_raster_counter #(
    .X_W(X_W), .Y_W(Y_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX)
  ) u_fill (
    .clk_i(CLK), .rst_ni(RESET),
    .clr_i(f_clr), .en_i(f_en),
    .ld_x_i(1'b0), .ld_y_i(1'b0),
    .x_i('0), .y_i('0),
    .x_o(fx), .y_o(fy), .last_o(f_last)
  );

  assign go_erase = ctrl_q[CTRL_ERASE] && prev_v_q
                    && (prev_q != last_q);
  assign ret_idle = (state_q == ST_WRITE && !go_erase)
                    || (state_q == ST_ERASE)
                    || (state_q == ST_FILL && f_last);
  assign pix_ok   = wr_pix && (state_q == ST_IDLE || ret_idle);
  assign fill_ok  = wr_fill && (state_q == ST_IDLE);
  assign drop_set = (wr_pix && !pix_ok) || (wr_fill && !fill_ok);

  always_comb begin
    state_d   = state_q;
    fb_we_d   = 1'b0;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    cur_en    = 1'b0;
    f_clr     = 1'b0;
    f_en      = 1'b0;
    unique case (state_q)
      ST_WRITE: begin
        if (go_erase) begin
          state_d   = ST_ERASE;
          fb_we_d   = 1'b1;
          fb_addr_d = prev_q;
          fb_data_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ERASE: state_d = ST_IDLE;
      ST_FILL: begin
        if (f_last) begin
          state_d = ST_IDLE;
        end else begin
          f_en    = 1'b1;
          fb_we_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (pix_ok) begin
      state_d   = ST_WRITE;
      fb_we_d   = 1'b1;
      fb_addr_d = {cy, cx};
      fb_data_d = BUS_DATA[PIX_W-1:0];
      cur_en    = ctrl_q[CTRL_AINC];
    end
    if (fill_ok) begin
      state_d   = ST_FILL;
      fb_we_d   = 1'b1;
      fb_data_d = BUS_DATA[PIX_W-1:0];
      f_clr     = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      fb_we_q   <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
      last_q    <= '0;
      prev_q    <= '0;
      last_v_q  <= 1'b0;
      prev_v_q  <= 1'b0;
      drop_q    <= 1'b0;
      ctrl_q    <= CTRL_INIT;
      bg_q      <= BG_INIT;
      fg_q      <= FG_INIT;
    end else begin
      state_q   <= state_d;
      fb_we_q   <= fb_we_d;
      fb_addr_q <= fb_addr_d;
      fb_data_q <= fb_data_d;
      if (wr_ctrl)
        ctrl_q <= {BUS_DATA[CTRL_ERASE], BUS_DATA[CTRL_AINC]};
      if (wr_bg) bg_q <= COLOUR_W'(BUS_DATA);
      if (wr_fg) fg_q <= COLOUR_W'(BUS_DATA);
      if (drop_set)
        drop_q <= 1'b1;
      else if (wr_ctrl && BUS_DATA[CTRL_DCLR])
        drop_q <= 1'b0;
      if (fill_ok) begin
        last_v_q <= 1'b0;
        prev_v_q <= 1'b0;
      end else if (pix_ok) begin
        prev_q   <= last_q;
        prev_v_q <= last_v_q;
        last_q   <= {cy, cx};
        last_v_q <= 1'b1;
      end
    end
  end

  // During a fill the raster counter itself is the address being written.
  assign FB_ADDR = (state_q == ST_FILL) ? {fy, fx} : fb_addr_q;
  assign FB_DATA = fb_data_q;
  assign FB_WE   = fb_we_q;
  assign CONFIG_COLOURS = {bg_q, fg_q};
  assign BUSY = (state_q == ST_FILL) || (state_q == ST_ERASE)
                || (state_q == ST_WRITE && go_erase);
  assign DROP = drop_q;

`ifdef VGA_BUS_PIXEL_READBACK_EN
  logic [7:0] rd_q, rd_d;

  always_comb begin
    rd_d = '0;
    if (in_win) begin
      unique case (off[2:0])
        OFF_X:    rd_d = 8'(cx);
        OFF_Y:    rd_d = 8'(cy);
        OFF_BG:   rd_d = 8'(bg_q);
        OFF_FG:   rd_d = 8'(fg_q);
        OFF_CTRL: rd_d = {DROP, BUSY, 4'b0, ctrl_q};
        default:  rd_d = '0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) rd_q <= '0;
    else        rd_q <= rd_d;
  end

  assign BUS_RDATA = rd_q;
`endif

endmodule

// File: tb/tb_vga_bus_pixel_ctrl.sv
// Directed + randomized bench for vga_bus_pixel_ctrl against a
// coordinate/index-level reference model.
module tb_vga_bus_pixel_ctrl;

  localparam logic [7:0] B = 8'hB0;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  BUS_ADDR, BUS_DATA;
  logic        BUS_WE;
  logic [14:0] FB_ADDR;
  logic [0:0]  FB_DATA;
  logic        FB_WE;
  logic [15:0] CONFIG_COLOURS;
  logic        BUSY, DROP;
`ifdef VGA_BUS_PIXEL_READBACK_EN
  logic [7:0]  BUS_RDATA;
`endif

  vga_bus_pixel_ctrl dut (
    .CLK(CLK), .RESET(RESET),
    .BUS_ADDR(BUS_ADDR), .BUS_DATA(BUS_DATA), .BUS_WE(BUS_WE),
    .FB_ADDR(FB_ADDR), .FB_DATA(FB_DATA), .FB_WE(FB_WE),
    .CONFIG_COLOURS(CONFIG_COLOURS),
    .BUSY(BUSY), .DROP(DROP)
`ifdef VGA_BUS_PIXEL_READBACK_EN
    , .BUS_RDATA(BUS_RDATA)
`endif
  );

  always #5 CLK = ~CLK;

  int errs = 0;
  int checks = 0;

  // reference model state
  int mx, my, mctrl, mlast, mprev, mbg, mfg;
  bit mlast_v, mer;

  function automatic int fa(int x, int y);
    return y * 256 + x;
  endfunction
  function automatic int clx(int d);
    return (d % 256) > 159 ? 159 : d % 256;
  endfunction
  function automatic int cly(int d);
    return (d % 128) > 119 ? 119 : d % 128;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic [7:0] a, input logic [7:0] d);
    BUS_ADDR = a;
    BUS_DATA = d;
    BUS_WE   = 1'b1;
    @(negedge CLK);
    BUS_WE   = 1'b0;
  endtask

  task automatic idle();
    @(negedge CLK);
  endtask

  task automatic adv();
    int idx;
    idx = (my * 160 + mx + 1) % 19200;
    mx = idx % 160;
    my = idx / 160;
  endtask

  task automatic setx(input int d);
    bus(B, 8'(d));
    mx = clx(d);
  endtask

  task automatic sety(input int d);
    bus(B + 8'd1, 8'(d));
    my = cly(d);
  endtask

  task automatic setctrl(input int c);
    bus(B + 8'd5, 8'(c));
    mctrl = c & 3;
  endtask

  task automatic pix(input string tag, input int d);
    int cur;
    cur = fa(mx, my);
    bus(B + 8'd2, 8'(d));
    chk({tag, "_we"}, 32'(FB_WE), 1);
    chk({tag, "_addr"}, 32'(FB_ADDR), cur);
    chk({tag, "_data"}, 32'(FB_DATA), d & 1);
    mer = ((mctrl >> 1) & 1) == 1 && mlast_v && mlast != cur;
    mprev = mlast;
    mlast = cur;
    mlast_v = 1'b1;
    if ((mctrl & 1) == 1) adv();
  endtask

  task automatic post(input string tag);
    idle();
    if (mer) begin
      chk({tag, "_we"}, 32'(FB_WE), 1);
      chk({tag, "_addr"}, 32'(FB_ADDR), mprev);
      chk({tag, "_data"}, 32'(FB_DATA), 0);
    end else begin
      chk({tag, "_we"}, 32'(FB_WE), 0);
    end
  endtask

  initial begin
    int nwe, bad, first, lasta, cnt;
    RESET = 1'b0;
    BUS_ADDR = '0;
    BUS_DATA = '0;
    BUS_WE = 1'b0;
    mx = 0; my = 0; mctrl = 2; mlast = 0; mprev = 0;
    mlast_v = 0; mer = 0; mbg = 8'h33; mfg = 8'hCC;

    repeat (2) @(negedge CLK);
    chk("rst_we", 32'(FB_WE), 0);
    chk("rst_addr", 32'(FB_ADDR), 0);
    chk("rst_data", 32'(FB_DATA), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_drop", 32'(DROP), 0);
    chk("rst_col", 32'(CONFIG_COLOURS), 32'h33CC);
    RESET = 1'b1;
    idle();

    // single pixel, erase off
    setctrl(0);
    setx(5);
    sety(3);
    pix("px0", 1);
    post("px0_post");
    chk("px0_busy", 32'(BUSY), 0);

    // erase-previous with back-to-back pixels, then a dropped one
    setctrl(3);
    setx(5);
    sety(3);
    pix("er_a", 1);
    chk("er_a_busy", 32'(BUSY), 0);
    pix("er_b", 1);
    chk("er_b_busy", 32'(BUSY), 1);
    bus(B + 8'd2, 8'd1);
    chk("er_we", 32'(FB_WE), 1);
    chk("er_addr", 32'(FB_ADDR), mprev);
    chk("er_data", 32'(FB_DATA), 0);
    chk("er_busy", 32'(BUSY), 1);
    chk("er_drop", 32'(DROP), 1);
    idle();
    chk("er_end_we", 32'(FB_WE), 0);
    chk("er_end_busy", 32'(BUSY), 0);
    setctrl(8'h81);
    chk("drop_clr", 32'(DROP), 0);

    // auto-increment wrap at the bottom-right corner
    setx(159);
    sety(119);
    pix("wrap_a", 1);
    pix("wrap_b", 0);
    post("wrap_post");

    // truncate then clamp
    setx(200);
    sety(200);
    pix("clamp_a", 1);
    post("clamp_a_post");
    sety(127);
    pix("clamp_b", 1);
    post("clamp_b_post");

    // colours and ignored writes
    bus(B + 8'd3, 8'hF0);
    mbg = 8'hF0;
    chk("col_bg", 32'(CONFIG_COLOURS), (mbg << 8) | mfg);
    bus(B + 8'd4, 8'h5A);
    mfg = 8'h5A;
    chk("col_fg", 32'(CONFIG_COLOURS), (mbg << 8) | mfg);
    bus(8'hB8, 8'h11);
    bus(8'hAF, 8'h11);
    bus(B + 8'd7, 8'h11);
    chk("ign_col", 32'(CONFIG_COLOURS), (mbg << 8) | mfg);
    chk("ign_we", 32'(FB_WE), 0);
    chk("ign_drop", 32'(DROP), 0);

    // full-screen fill with a pixel write landing mid-fill
    bus(B + 8'd6, 8'h00);
    nwe = 0; bad = 0; first = -1; lasta = -1;
    for (int c = 0; c < 20000 && FB_WE === 1'b1; c++) begin
      if (nwe == 0) first = int'(FB_ADDR);
      lasta = int'(FB_ADDR);
      if (FB_ADDR !== 15'(fa(nwe % 160, nwe / 160))
          || FB_DATA !== 1'b0 || BUSY !== 1'b1)
        bad++;
      nwe++;
      if (nwe == 50) begin
        BUS_ADDR = B + 8'd2;
        BUS_DATA = 8'd1;
        BUS_WE = 1'b1;
      end
      @(negedge CLK);
      BUS_WE = 1'b0;
    end
    mlast_v = 0;
    chk("fill_count", 32'(nwe), 19200);
    chk("fill_order", 32'(bad), 0);
    chk("fill_first", 32'(first), 0);
    chk("fill_last", 32'(lasta), fa(159, 119));
    chk("fill_busy_end", 32'(BUSY), 0);
    chk("fill_drop", 32'(DROP), 1);
    setctrl(8'h81);
    chk("fill_drop_clr", 32'(DROP), 0);

    // randomized cursor / control / pixel traffic
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1, 0) == 1) setx(int'($urandom_range(255, 0)));
      if ($urandom_range(1, 0) == 1) sety(int'($urandom_range(255, 0)));
      setctrl(int'($urandom_range(3, 0)));
      pix($sformatf("rnd%0d", i), int'($urandom_range(255, 0)));
      post($sformatf("rnd%0d_post", i));
      idle();
      chk($sformatf("rnd%0d_idle", i), 32'(FB_WE), 0);
      chk($sformatf("rnd%0d_busy", i), 32'(BUSY), 0);
    end

    // asynchronous reset at fill word 100
    bus(B + 8'd6, 8'h01);
    repeat (99) idle();
    chk("mid_we", 32'(FB_WE), 1);
    chk("mid_addr", 32'(FB_ADDR), fa(99, 0));
    chk("mid_data", 32'(FB_DATA), 1);
    chk("mid_busy", 32'(BUSY), 1);
    RESET = 1'b0;
    #1;
    chk("arst_we", 32'(FB_WE), 0);
    chk("arst_busy", 32'(BUSY), 0);
    chk("arst_addr", 32'(FB_ADDR), 0);
    chk("arst_col", 32'(CONFIG_COLOURS), 32'h33CC);
    @(negedge CLK);
    RESET = 1'b1;
    mx = 0; my = 0; mctrl = 2; mlast_v = 0;
    cnt = 0;
    repeat (10) begin
      idle();
      if (FB_WE !== 1'b0) cnt++;
    end
    chk("arst_quiet", 32'(cnt), 0);

    // control reset value: erase on, auto-increment off
    pix("pr_a", 1);
    post("pr_a_post");
    pix("pr_b", 1);
    post("pr_b_post");
    setx(9);
    pix("pr_c", 1);
    post("pr_c_post");
    idle();
    chk("pr_end", 32'(FB_WE), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
